// File: rtl/systolic_skew_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder_if
// Bundles the upstream beat handshake and the array-edge outputs of the
// systolic skew feeder.
//   in_valid / in_ready / in_last : upstream beat handshake
//   in_a / in_b                   : N-lane A column and B row of one k-slice
//   a_edge / b_edge               : skewed lanes to the west / north edges
//   array_en / done               : array-wide enable, completion pulse
//   beat_cnt                      : saturating count of accepted beats
// master = upstream source, slave = feeder.
// ---------------------------------------------------------------------------
interface systolic_skew_feeder_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int CW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [N*DW-1:0] in_a;
  logic [N*DW-1:0] in_b;
  logic [N*DW-1:0] a_edge;
  logic [N*DW-1:0] b_edge;
  logic            array_en;
  logic            done;
  logic [CW-1:0]   beat_cnt;

  modport master (
    output in_valid, in_last, in_a, in_b,
    input  in_ready, a_edge, b_edge, array_en, done, beat_cnt
  );

  modport slave (
    input  in_valid, in_last, in_a, in_b,
    output in_ready, a_edge, b_edge, array_en, done, beat_cnt
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
// Upstream feeder for an N x N systolic multiply array. Accepts one k-slice
// per beat, skews lane i by i cycles onto the west (A) and north (B) edges,
// keeps the array enabled through the drain window and pulses done once the
// last slice has reached PE(N-1,N-1).
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : systolic_skew_feeder_if.slave (handshake, data, edges, status)
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  systolic_skew_feeder_if.slave bus
);

  // Drain lasts 2N-1 cycles: counter loads 2N-2 and counts down to 0.
  localparam int             DCW       = $clog2(2 * N - 1);
  localparam logic [DCW-1:0] DRAIN_LEN = DCW'(2 * N - 2);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t         state_q;
  logic [DCW-1:0] drain_q;
  logic           in_ready_q;
  logic           array_en_q;
  logic           done_q;
  logic [CW-1:0]  beat_cnt_q;
  logic           xfer;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // in_ready is a registered function of state only.
  assign xfer = bus.in_valid && in_ready_q;

  // ---- control FSM: all outputs registered -------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      in_ready_q <= 1'b1;
      array_en_q <= 1'b0;
      done_q     <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            beat_cnt_q <= CW'(1);
            array_en_q <= 1'b1;
            if (bus.in_last) begin
              state_q    <= DRAIN;
              drain_q    <= DRAIN_LEN;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            beat_cnt_q <= sat_inc(beat_cnt_q);
            if (bus.in_last) begin
              state_q    <= DRAIN;
              drain_q    <= DRAIN_LEN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q    <= DONE;
            array_en_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            drain_q <= drain_q - DCW'(1);
          end
        end
        DONE: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          array_en_q <= 1'b0;
        end
      endcase
    end
  end

  // ---- skew chains: lane i is i+1 registers deep ------------------------
  // Stage 0 takes the transferred element, or zero when no beat is accepted,
  // so stalls and the drain window push zero beats into the array.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_sr_q [0:i];
    logic [DW-1:0] b_sr_q [0:i];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int s = 0; s <= i; s++) begin
          a_sr_q[s] <= '0;
          b_sr_q[s] <= '0;
        end
      end else begin
        a_sr_q[0] <= xfer ? bus.in_a[i*DW +: DW] : '0;
        b_sr_q[0] <= xfer ? bus.in_b[i*DW +: DW] : '0;
        for (int s = i; s > 0; s--) begin
          a_sr_q[s] <= a_sr_q[s-1];
          b_sr_q[s] <= b_sr_q[s-1];
        end
      end
    end

    assign bus.a_edge[i*DW +: DW] = a_sr_q[i];
    assign bus.b_edge[i*DW +: DW] = b_sr_q[i];
  end

  assign bus.in_ready = in_ready_q;
  assign bus.array_en = array_en_q;
  assign bus.done     = done_q;
  assign bus.beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int W   = N * DW;
  localparam int SN  = 2;
  localparam int SDW = 8;
  localparam int SCW = 3;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  systolic_skew_feeder_if #(.N(N),  .DW(DW),  .CW(CW))  fif ();
  systolic_skew_feeder_if #(.N(SN), .DW(SDW), .CW(SCW)) sif ();

  systolic_skew_feeder #(.N(N), .DW(DW), .CW(CW)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .bus(fif)
  );
  systolic_skew_feeder #(.N(SN), .DW(SDW), .CW(SCW)) u_sat (
    .CLK(CLK), .RST_N(RST_N), .bus(sif)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ---------------------------
  // Timing is described by event times: the edge of the first and last
  // transfer of a product, and a history of what entered each lane.
  int            e;          // index of the most recent rising edge
  bit            active;     // a product has started
  bit            have_last;  // its last slice has been accepted
  int            t_last;
  int            beats;
  logic [W-1:0]  ha[$];      // ha[d] = A beat entering d edges ago
  logic [W-1:0]  hb[$];
  bit            rec;
  logic [W-1:0]  obs_a[$];
  logic [W-1:0]  obs_b[$];

  task automatic model_reset();
    active = 0; have_last = 0; beats = 0; t_last = 0;
    ha = {}; hb = {};
    for (int i = 0; i < N; i++) begin ha.push_back('0); hb.push_back('0); end
  endtask

  function automatic bit rdy_at(input int edge_i);
    return !(have_last && edge_i >= t_last + 1 && edge_i <= t_last + 2 * N);
  endfunction

  task automatic check_model();
    logic [W-1:0] ea, eb;
    bit en, dn;
    for (int i = 0; i < N; i++) begin
      ea[i*DW +: DW] = ha[i][i*DW +: DW];
      eb[i*DW +: DW] = hb[i][i*DW +: DW];
    end
    en = active && (!have_last || e <= t_last + 2 * N - 2);
    dn = have_last && (e == t_last + 2 * N - 1);
    chk("in_ready", W'(fif.in_ready), W'(rdy_at(e + 1)));
    chk("array_en", W'(fif.array_en), W'(en));
    chk("done",     W'(fif.done),     W'(dn));
    chk("beat_cnt", W'(fif.beat_cnt), W'(beats));
    chk("a_edge",   fif.a_edge, ea);
    chk("b_edge",   fif.b_edge, eb);
    if (rec) begin obs_a.push_back(fif.a_edge); obs_b.push_back(fif.b_edge); end
  endtask

  task automatic step(input bit v, input bit l, input logic [W-1:0] a, input logic [W-1:0] b);
    bit xf;
    fif.in_valid = v; fif.in_last = l; fif.in_a = a; fif.in_b = b;
    @(posedge CLK);
    e++;
    if (have_last && e > t_last + 2 * N) begin active = 0; have_last = 0; end
    xf = v && rdy_at(e);
    ha.push_front(xf ? a : '0); void'(ha.pop_back());
    hb.push_front(xf ? b : '0); void'(hb.pop_back());
    if (xf) begin
      if (!active) begin active = 1; beats = 1; end
      else if (beats < (1 << CW) - 1) beats++;
      if (l) begin have_last = 1; t_last = e; end
    end
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, '0);
  endtask

  function automatic logic [W-1:0] lanes(input int x0, input int x1, input int x2, input int x3);
    logic [W-1:0] v;
    v[0*DW +: DW] = DW'(x0); v[1*DW +: DW] = DW'(x1);
    v[2*DW +: DW] = DW'(x2); v[3*DW +: DW] = DW'(x3);
    return v;
  endfunction

  function automatic logic [W-1:0] onehot(input int k);
    logic [W-1:0] v;
    v = '0;
    v[k*DW +: DW] = DW'(1);
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  // Array model: PE(i,j) multiplies A lane i delayed j cycles by B lane j
  // delayed i cycles, using the observed edge outputs.
  task automatic check_identity(input string nm);
    longint acc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int c = 0; c < obs_a.size(); c++)
          if (c >= i && c >= j)
            acc += longint'(obs_a[c-j][i*DW +: DW]) * longint'(obs_b[c-i][j*DW +: DW]);
        chk(nm, W'(acc), W'(i == j));
      end
  endtask

  typedef struct {
    bit           vld;
    bit           lst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           en;
    bit           dn;
    bit           rdy;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    int           bc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros;
    bit got;

    // single-slice vectors, one row per cycle after the transfer edge
    tbl[0] = '{1'b1, 1'b1, lanes(1,2,3,4), lanes(5,6,7,8), 1'b1, 1'b0, 1'b0, lanes(1,0,0,0), lanes(5,0,0,0), 1};
    tbl[1] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, lanes(0,2,0,0), lanes(0,6,0,0), 1};
    tbl[2] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, lanes(0,0,3,0), lanes(0,0,7,0), 1};
    tbl[3] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, lanes(0,0,0,4), lanes(0,0,0,8), 1};
    tbl[4] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1};
    tbl[5] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1};
    tbl[6] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1};
    tbl[7] = '{1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1};
    tbl[8] = '{1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, '0, 1};

    fif.in_valid = 0; fif.in_last = 0; fif.in_a = '0; fif.in_b = '0;
    sif.in_valid = 0; sif.in_last = 0; sif.in_a = '0; sif.in_b = '0;
    e = 0; rec = 0;
    model_reset();

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", W'(fif.in_ready), W'(1));
    chk("rst_array_en", W'(fif.array_en), W'(0));
    chk("rst_done",     W'(fif.done),     W'(0));
    chk("rst_beat_cnt", W'(fif.beat_cnt), W'(0));
    chk("rst_a_edge",   fif.a_edge, '0);
    chk("rst_b_edge",   fif.b_edge, '0);
    RST_N = 1;
    idle(2);

    // single slice, table-driven
    for (int r = 0; r < 9; r++) begin
      step(tbl[r].vld, tbl[r].lst, tbl[r].a, tbl[r].b);
      chk($sformatf("tbl%0d_en", r),  W'(fif.array_en), W'(tbl[r].en));
      chk($sformatf("tbl%0d_dn", r),  W'(fif.done),     W'(tbl[r].dn));
      chk($sformatf("tbl%0d_rdy", r), W'(fif.in_ready), W'(tbl[r].rdy));
      chk($sformatf("tbl%0d_a", r),   fif.a_edge, tbl[r].ea);
      chk($sformatf("tbl%0d_b", r),   fif.b_edge, tbl[r].eb);
      chk($sformatf("tbl%0d_bc", r),  W'(fif.beat_cnt), W'(tbl[r].bc));
    end

    // identity product, back-to-back slices
    obs_a = {}; obs_b = {}; rec = 1;
    for (int k = 0; k < N; k++) step(1, k == N - 1, onehot(k), onehot(k));
    idle(2 * N + 1);
    rec = 0;
    check_identity("ident_C");
    chk("ident_beat_cnt", W'(fif.beat_cnt), W'(4));

    // identity product with a 3-cycle stall between slices 1 and 2
    obs_a = {}; obs_b = {}; rec = 1;
    for (int k = 0; k < N; k++) begin
      if (k == 2) idle(3);
      step(1, k == N - 1, onehot(k), onehot(k));
    end
    idle(2 * N + 1);
    rec = 0;
    check_identity("stall_C");

    // backpressure: valid held through DRAIN and DONE
    step(1, 1, rnd_vec(), rnd_vec());
    zeros = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (fif.in_ready) got = 1; else zeros++;
      step(1, 1, rnd_vec(), rnd_vec());
    end
    chk("bp_got",   W'(got),   W'(1));
    chk("bp_stall", W'(zeros), W'(2 * N));
    idle(2 * N + 1);

    // asynchronous reset in the middle of DRAIN
    step(1, 1, lanes(9,9,9,9), lanes(3,3,3,3));
    idle(3);
    #2;
    RST_N = 0;
    #1;
    chk("mid_rst_array_en", W'(fif.array_en), W'(0));
    chk("mid_rst_in_ready", W'(fif.in_ready), W'(1));
    chk("mid_rst_done",     W'(fif.done),     W'(0));
    chk("mid_rst_beat_cnt", W'(fif.beat_cnt), W'(0));
    chk("mid_rst_a_edge",   fif.a_edge, '0);
    chk("mid_rst_b_edge",   fif.b_edge, '0);
    @(posedge CLK);
    #1;
    RST_N = 1;
    model_reset();
    idle(2 * N + 2);
    step(1, 1, lanes(1,2,3,4), lanes(5,6,7,8));
    idle(2 * N + 1);

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rnd_vec(), rnd_vec());
    idle(2 * N + 2);

    // beat counter saturation on the CW=3 instance
    for (int k = 1; k <= 9; k++) begin
      sif.in_valid = 1; sif.in_last = (k == 9);
      sif.in_a = 16'($urandom); sif.in_b = 16'($urandom);
      @(posedge CLK);
      #1;
      chk($sformatf("sat_beat%0d", k), W'(sif.beat_cnt), W'((k < 7) ? k : 7));
    end
    sif.in_valid = 0; sif.in_last = 0;
    repeat (2 * SN + 2) @(posedge CLK);
    #1;
    chk("sat_hold", W'(sif.beat_cnt), W'(7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
